// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the requester not granted last wins.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic i_a_valid,
  input  logic i_b_valid,
  input  req_t i_last_grant,
  output logic o_grant_valid,
  output req_t o_grant
);

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    o_grant_valid = i_a_valid | i_b_valid;
    o_grant       = REQ_A;
    if (i_a_valid && i_b_valid) begin
      o_grant = (i_last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (i_b_valid) begin
      o_grant = REQ_B;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: arbitrates ALU (A) and load (B) writebacks,
// runs the full-clear sequence and flags read-after-write hazards.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic              write_reg,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] writedata
);

  state_t              r_state;
  req_t                r_last_grant;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_write_reg;
  logic [ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]   r_writedata;

  logic                w_grant_valid;
  req_t                w_grant;
  logic                w_run;
  logic                w_xfer;
  logic                w_drop;
  logic [ADDR_W-1:0]   w_sel_rd;
  logic [DATA_W-1:0]   w_sel_data;

  rr_arb2 u_arb (
    .i_a_valid     (a_valid),
    .i_b_valid     (b_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  assign w_run      = (r_state == ST_RUN);
  assign a_ready    = w_run && w_grant_valid && (w_grant == REQ_A);
  assign b_ready    = w_run && w_grant_valid && (w_grant == REQ_B);
  assign w_xfer     = a_ready | b_ready;
  assign w_sel_rd   = (w_grant == REQ_A) ? a_rd   : b_rd;
  assign w_sel_data = (w_grant == REQ_A) ? a_data : b_data;
  // Writes to r0 are swallowed: handshake completes but nothing reaches the file.
  assign w_drop     = DROP_R0 && (w_sel_rd == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_last_grant <= REQ_B;
      r_clr_cnt    <= '0;
      r_write_reg  <= 1'b0;
      r_rd         <= '0;
      r_writedata  <= '0;
    end else if (r_state == ST_RUN) begin
      r_write_reg <= w_xfer && !w_drop;
      if (w_xfer) begin
        r_last_grant <= w_grant;
        if (!w_drop) begin
          r_rd        <= w_sel_rd;
          r_writedata <= w_sel_data;
        end
      end
      if (clr_req) r_state <= ST_CLEAR;
    end else begin
      r_write_reg <= 1'b1;
      r_rd        <= r_clr_cnt;
      r_writedata <= '0;
      r_clr_cnt   <= r_clr_cnt + ADDR_W'(1);
      if (r_clr_cnt == '1) begin
        r_state   <= ST_RUN;
        r_clr_cnt <= '0;
      end
    end
  end

  assign clr_busy  = (r_state == ST_CLEAR);
  assign write_reg = r_write_reg;
  assign rd        = r_rd;
  assign writedata = r_writedata;

  // The file reads on the edge this write lands, so a matching read sees stale data.
  assign hazard_rs = r_write_reg && (r_rd == rs) && (rs != '0);
  assign hazard_rt = r_write_reg && (r_rd == rt) && (rt != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, r0 drop, clear sequence, hazards, reset abort.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        clr_busy;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, rs, rt, rd;
  logic [31:0] a_data, b_data, writedata;
  logic        hazard_rs, hazard_rt, write_reg;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_R0(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .rs        (rs),
    .rt        (rt),
    .hazard_rs (hazard_rs),
    .hazard_rt (hazard_rt),
    .write_reg (write_reg),
    .rd        (rd),
    .writedata (writedata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    rs = '0; rt = '0;
    #1;
    do_reset();

    // Reset state
    check("rst_write_reg", write_reg, 0);
    check("rst_rd",        rd, 0);
    check("rst_writedata", writedata, 0);
    check("rst_clr_busy",  clr_busy, 0);
    check("rst_a_ready",   a_ready, 0);
    check("rst_b_ready",   b_ready, 0);

    // 1: single A write, one-cycle latency
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
    #1;
    check("t1_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("t1_write_reg", write_reg, 1);
    check("t1_rd",        rd, 5);
    check("t1_writedata", writedata, 32'h11);
    tick();
    check("t1_idle_write_reg", write_reg, 0);
    check("t1_idle_rd_held",   rd, 5);

    // 2: tie held for 4 cycles from a fresh reset -> A,B,A,B
    do_reset();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t2_a_ready_%0d", i), a_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t2_b_ready_%0d", i), b_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("t2_write_reg_%0d", i), write_reg, 1);
      check($sformatf("t2_rd_%0d", i), rd, (i % 2 == 0) ? 3 : 4);
      check($sformatf("t2_data_%0d", i), writedata, (i % 2 == 0) ? 32'hA : 32'hB);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // 3: A write (last_grant=A), dropped B write to r0 (last_grant=B), tie -> A
    a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h22;
    tick();
    a_valid = 1'b0;
    check("t3_pre_rd", rd, 2);
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h55;
    #1;
    check("t3_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    check("t3_drop_write_reg", write_reg, 0);
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'hB;
    #1;
    check("t3_tie_a_ready", a_ready, 1);
    check("t3_tie_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("t3_tie_rd", rd, 3);

    // 4: clear pulse together with an accepted A write to r7
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77; clr_req = 1'b1;
    #1;
    check("t4_a_ready", a_ready, 1);
    tick();
    clr_req = 1'b0;
    a_rd = 5'd9; a_data = 32'h99;
    check("t4_first_write_reg", write_reg, 1);
    check("t4_first_rd",        rd, 7);
    check("t4_first_data",      writedata, 32'h77);
    check("t4_first_a_ready",   a_ready, 0);
    busy_cycles = clr_busy ? 1 : 0;
    for (int k = 0; k < 32; k++) begin
      clr_req = (k == 5);
      tick();
      check($sformatf("t4_clr_we_%0d", k), write_reg, 1);
      check($sformatf("t4_clr_rd_%0d", k), rd, k);
      check($sformatf("t4_clr_data_%0d", k), writedata, 0);
      check($sformatf("t4_clr_a_ready_%0d", k), a_ready, (k == 31) ? 1 : 0);
      if (k == 0) check("t5_hazard_rs_r0", hazard_rs, 0);
      if (clr_busy) busy_cycles++;
    end
    clr_req = 1'b0;
    check("t4_busy_cycles", busy_cycles, 32);
    check("t4_clr_busy_done", clr_busy, 0);

    // 5: pending A write to r9 lands after the clear; hazards against it
    rs = 5'd9; rt = 5'd9;
    tick();
    a_valid = 1'b0;
    check("t5_rd", rd, 9);
    check("t5_hazard_rs", hazard_rs, 1);
    check("t5_hazard_rt", hazard_rt, 1);
    rt = 5'd8;
    #1;
    check("t5_hazard_rt_miss", hazard_rt, 0);
    rs = '0; rt = '0;

    // 6: reset aborts a clear at cycle 10
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("t6_busy", clr_busy, 1);
    for (int k = 0; k < 10; k++) tick();
    check("t6_rd_before_abort", rd, 9);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t6_busy_after_rst", clr_busy, 0);
    check("t6_we_after_rst",   write_reg, 0);
    a_valid = 1'b1; a_rd = 5'd12; a_data = 32'h12;
    #1;
    check("t6_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("t6_rd", rd, 12);
    check("t6_data", writedata, 32'h12);
    tick();
    check("t6_no_more_clear_we", write_reg, 0);
    check("t6_no_more_clear_busy", clr_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
